store_2_hex: RTL and testbench
==============================

STORE_2_HEX -- requirements
Module: store_2_hex

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; these are fixed.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous active-high reset.
REQ-004 Port: hex_in  input  4  hex digit to store.
REQ-005 Port: is_guessing_pw  input  1  target select: 1 = guess register, 0 = actual-password register.
REQ-006 Port: enter  input  1  asynchronous push-button strobe; each low-to-high transition commits one digit.
REQ-007 Port: guess_pw  output  16  guess register, four hex digits; [15:12] is the oldest digit, [3:0] the newest.
REQ-008 Port: actual_pw  output  16  actual-password register, same digit order as guess_pw.
REQ-009 Parameter: none; all widths are fixed.

Function
REQ-010 enter SHALL pass through a 2-flop synchronizer (enter_s1, enter_s2) clocked by clk.
REQ-011 A registered copy enter_d of enter_s2 SHALL be kept; press = enter_s2 & ~enter_d.
REQ-012 On a clk edge with press=1 and is_guessing_pw=1:
  - guess_pw SHALL load {guess_pw[11:0], hex_in};
  - actual_pw SHALL hold.
REQ-013 On a clk edge with press=1 and is_guessing_pw=0:
  - actual_pw SHALL load {actual_pw[11:0], hex_in};
  - guess_pw SHALL hold.
REQ-014 hex_in and is_guessing_pw SHALL be sampled directly, unsynchronized, on the edge where press=1.
  - They must be stable from enter rising until enter falling.
  - Values outside that window have no effect.
REQ-015 Latency: the register update SHALL be visible after the 3rd rising clk edge following enter rising, given enter meets setup time.
REQ-016 Holding enter high SHALL commit exactly one digit; no auto-repeat.
REQ-017 enter SHALL be high at least 3 clk cycles and low at least 3 clk cycles between presses; shorter pulses may be lost.
REQ-018 Wrap-around: after more than 4 presses, the oldest digit SHALL shift out of [15:12] and is discarded; there is no digit counter and no full flag.
REQ-019 If is_guessing_pw toggles between presses, each register SHALL keep its own contents independently.
REQ-020 Outputs SHALL be driven directly from the storage flops; there is no combinational path from inputs to outputs.

Reset
REQ-021 While reset=1, the following SHALL be 0 asynchronously:
  - guess_pw = 16'h0000;
  - actual_pw = 16'h0000;
  - enter_s1, enter_s2 and enter_d.
REQ-022 A press in progress when reset asserts SHALL be discarded.
REQ-023 After reset deasserts, an enter already held high SHALL count as one new press once it propagates; this follows because enter_d resets to 0.

Verification
REQ-024 Reset, is_guessing_pw=1, hex_in=F, 4 presses -> guess_pw=FFFF, actual_pw=0000.
REQ-025 Continue with is_guessing_pw=0, hex_in=0, 4 presses -> actual_pw=0000, guess_pw=FFFF unchanged. Then is_guessing_pw=1, hex_in=A, 4 presses -> guess_pw=AAAA, actual_pw=0000.
REQ-026 is_guessing_pw=0, digits 1,2,3,4 -> actual_pw=1234. A 5th press with digit 5 -> actual_pw=2345, guess_pw unchanged.
REQ-027 enter held high for 50 cycles with hex_in=7 -> exactly one shift: guess_pw goes 0000 -> 0007.
REQ-028 After guess_pw=1234, assert reset mid-press, asynchronously off the clock edge -> both outputs read 0000 immediately. After release with enter low, the next press with digit 9 -> 0009.
REQ-029 Latency check: enter rises just before clk edge N -> the output changes at edge N+2 and no earlier.

Source files
------------

// File: rtl/store_2_hex.sv
// Keypad digit store: each synchronized enter press shifts hex_in into the guess
// or actual-password register, selected by is_guessing_pw.
module store_2_hex (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  hex_in,
  input  logic        is_guessing_pw,
  input  logic        enter,
  output logic [15:0] guess_pw,
  output logic [15:0] actual_pw
);

  logic enter_s1, enter_s2, enter_d;
  logic press;

  // enter is an asynchronous button, so it crosses into clk through two flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enter_s1 <= 1'b0;
      enter_s2 <= 1'b0;
      enter_d  <= 1'b0;
    end else begin
      enter_s1 <= enter;
      enter_s2 <= enter_s1;
      enter_d  <= enter_s2;
    end
  end

  assign press = enter_s2 & ~enter_d;

  // hex_in and is_guessing_pw are held stable by the user for the whole press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      guess_pw  <= 16'h0000;
      actual_pw <= 16'h0000;
    end else if (press) begin
      if (is_guessing_pw) guess_pw  <= {guess_pw[11:0], hex_in};
      else                actual_pw <= {actual_pw[11:0], hex_in};
    end
  end

endmodule

// File: tb/tb_store_2_hex.sv
// Directed and randomized checks of store_2_hex against a digit-history model.
module tb_store_2_hex;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  hex_in = 4'h0;
  logic        is_guessing_pw = 1'b0;
  logic        enter = 1'b0;
  logic [15:0] guess_pw, actual_pw;

  int vectors = 0;
  int miscompares = 0;

  // model: full history of committed digits per register
  int g_hist[$];
  int a_hist[$];

  store_2_hex dut (
    .clk(clk), .reset(reset), .hex_in(hex_in), .is_guessing_pw(is_guessing_pw),
    .enter(enter), .guess_pw(guess_pw), .actual_pw(actual_pw)
  );

  always #5 clk = ~clk;

  // value of the newest four digits, newest in the low nibble
  function automatic logic [15:0] last4(input int h[$]);
    int v = 0;
    int n = h.size();
    for (int i = 0; i < 4; i++)
      if (n - 1 - i >= 0) v += h[n - 1 - i] * (16 ** i);
    return v[15:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, " guess"}, guess_pw, last4(g_hist));
    check({tag, " actual"}, actual_pw, last4(a_hist));
  endtask

  task automatic model_press(input int d, input bit sel);
    if (sel) g_hist.push_back(d);
    else     a_hist.push_back(d);
  endtask

  task automatic press(input int d, input bit sel, input int hi, input int lo);
    @(negedge clk);
    hex_in = d[3:0];
    is_guessing_pw = sel;
    enter = 1'b1;
    repeat (hi) @(negedge clk);
    enter = 1'b0;
    repeat (lo) @(negedge clk);
    model_press(d, sel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    g_hist.delete();
    a_hist.delete();
    check_both("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    for (int i = 0; i < 4; i++) press(15, 1'b1, 3, 3);
    check_both("guess FFFF");
    for (int i = 0; i < 4; i++) press(0, 1'b0, 3, 3);
    check_both("actual 0000");
    for (int i = 0; i < 4; i++) press(10, 1'b1, 4, 3);
    check_both("guess AAAA");

    for (int i = 1; i <= 4; i++) press(i, 1'b0, 3, 4);
    check_both("actual 1234");
    press(5, 1'b0, 3, 4);
    check_both("actual wrap 2345");

    // a long hold commits one digit only
    do_reset();
    press(7, 1'b1, 50, 4);
    check_both("hold 50");

    // reset asserted between clock edges while a press is in flight
    for (int i = 1; i <= 4; i++) press(i, 1'b1, 3, 3);
    check_both("guess 1234");
    @(negedge clk);
    hex_in = 4'h8;
    is_guessing_pw = 1'b1;
    enter = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    g_hist.delete();
    a_hist.delete();
    check_both("async reset");
    enter = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_both("after reset idle");
    press(9, 1'b1, 3, 3);
    check_both("post reset 0009");

    // latency: enter rises just before edge N, change lands on N+2
    @(negedge clk);
    hex_in = 4'hC;
    is_guessing_pw = 1'b0;
    #4 enter = 1'b1;
    @(posedge clk); #1;
    check("lat N", actual_pw, last4(a_hist));
    @(posedge clk); #1;
    check("lat N+1", actual_pw, last4(a_hist));
    @(posedge clk); #1;
    model_press(12, 1'b0);
    check("lat N+2", actual_pw, last4(a_hist));
    repeat (2) @(negedge clk);
    enter = 1'b0;
    repeat (4) @(negedge clk);
    check_both("lat settle");

    // enter already high at reset release counts as one press
    @(negedge clk);
    reset = 1'b1;
    enter = 1'b1;
    hex_in = 4'h3;
    is_guessing_pw = 1'b1;
    g_hist.delete();
    a_hist.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    model_press(3, 1'b1);
    check_both("held through reset");
    enter = 1'b0;
    repeat (4) @(negedge clk);
    check_both("held through reset release");

    // randomized presses: digit, target and timing
    for (int i = 0; i < 60; i++) begin
      press(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
            int'($urandom_range(3, 8)), int'($urandom_range(3, 8)));
      check_both("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
